// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory and the data cache controller that talks to it.
// Block geometry, FSM state encoding and the latched request record.
package data_memory_pkg;

    localparam int unsigned BLOCK_WIDTH      = 128;
    localparam int unsigned BLOCK_ADDR_WIDTH = 28;
    localparam int unsigned CNT_WIDTH        = 4;

    typedef logic [BLOCK_WIDTH-1:0]      block_t;
    typedef logic [BLOCK_ADDR_WIDTH-1:0] block_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Request captured on the IDLE->BUSY transition; governs the whole access.
    typedef struct packed {
        logic        write;
        block_addr_t addr;
        block_t      data;
    } mem_req_t;

    // Busy-cycle count to load, saturated into the counter width.
    function automatic logic [CNT_WIDTH-1:0] latency_load_value(input int unsigned latency);
        int unsigned v;
        v = (latency == 0) ? 0 : latency - 1;
        if (v > (2 ** CNT_WIDTH) - 1) begin
            v = (2 ** CNT_WIDTH) - 1;
        end
        return CNT_WIDTH'(v);
    endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter that paces a memory access; flags when the count has reached zero.
module mem_latency_counter
    import data_memory_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (decrement && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/data_memory.sv
// Block-wide data memory with fixed access latency (IDLE -> BUSY -> DONE handshake).
// Optional DATA_MEMORY_PROTOCOL_CHECK_EN adds a sticky PROTOCOL_ERR output.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned LATENCY    = 5,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        READ,
    input  logic                        WRITE,
    input  logic [BLOCK_ADDR_WIDTH-1:0] ADDRESS,
    input  logic [BLOCK_WIDTH-1:0]      WRITEDATA,
    output logic [BLOCK_WIDTH-1:0]      READDATA,
    output logic                        BUSYWAIT
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
    ,
    output logic                        PROTOCOL_ERR
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CNT_WIDTH-1:0] LOAD_VALUE = latency_load_value(LATENCY);

    mem_state_e state_q, state_d;
    mem_req_t   req_q;
    block_t     readdata_q;
    block_t     mem_q [DEPTH];

    logic                  req_valid;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_zero;
    logic                  do_access;
    logic [DEPTH_LOG2-1:0] mem_idx;

    assign req_valid = READ | WRITE;
    assign do_access = (state_q == BUSY) && cnt_zero;
    // Upper address bits alias onto the same block.
    assign mem_idx   = req_q.addr[DEPTH_LOG2-1:0];

    mem_latency_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (cnt_load),
        .load_value (LOAD_VALUE),
        .decrement  (cnt_dec),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        BUSYWAIT = 1'b0;
        unique case (state_q)
            IDLE: begin
                BUSYWAIT = req_valid;
                if (req_valid) begin
                    state_d  = BUSY;
                    cnt_load = 1'b1;
                end
            end
            BUSY: begin
                BUSYWAIT = 1'b1;
                if (cnt_zero) begin
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (RESET) begin
            BUSYWAIT = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A simultaneous READ and WRITE is latched as a write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_q <= '0;
        end else if ((state_q == IDLE) && req_valid) begin
            req_q.write <= WRITE;
            req_q.addr  <= ADDRESS;
            req_q.data  <= WRITEDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            readdata_q <= '0;
        end else if (do_access && !req_q.write) begin
            readdata_q <= mem_q[mem_idx];
        end
    end

    // Array is never cleared; a reset in the completing cycle suppresses the write.
    always_ff @(posedge CLK) begin
        if (!RESET && do_access && req_q.write) begin
            mem_q[mem_idx] <= req_q.data;
        end
    end

    assign READDATA = readdata_q;

`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
    logic protocol_err_q;
    logic violation;

    always_comb begin
        violation = 1'b0;
        if (state_q == IDLE) begin
            violation = READ & WRITE;
        end else if (state_q == BUSY) begin
            violation = (req_q.write ? !WRITE : !READ) || (ADDRESS != req_q.addr);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            protocol_err_q <= 1'b0;
        end else if (violation) begin
            protocol_err_q <= 1'b1;
        end
    end

    assign PROTOCOL_ERR = protocol_err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_q.addr[BLOCK_ADDR_WIDTH-1:DEPTH_LOG2];
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: vector table, corner-case sequences, random vs. array model.
module tb_data_memory;

    localparam int LAT = 5;
    localparam logic [127:0] D1 = 128'h44443333222211110000FFFF0000AAAA;
    localparam logic [127:0] D2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] D3 = 128'h0BADC0DE_11111111_22222222_33333333;
    localparam logic [127:0] D4 = 128'h77777777_66666666_55555555_44444444;
    localparam logic [127:0] D5 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         READ, WRITE, READ1, WRITE1;
    logic [27:0]  ADDRESS, ADDRESS1;
    logic [127:0] WRITEDATA, WRITEDATA1, READDATA, READDATA1;
    logic         BUSYWAIT, BUSYWAIT1;
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
    logic         PROTOCOL_ERR, PROTOCOL_ERR1;
`endif

    always #5 CLK = ~CLK;

    data_memory #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT)
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
        , .PROTOCOL_ERR(PROTOCOL_ERR)
`endif
    );

    data_memory #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
        .CLK(CLK), .RESET(RESET), .READ(READ1), .WRITE(WRITE1), .ADDRESS(ADDRESS1),
        .WRITEDATA(WRITEDATA1), .READDATA(READDATA1), .BUSYWAIT(BUSYWAIT1)
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
        , .PROTOCOL_ERR(PROTOCOL_ERR1)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain block array, wrapping by modulo of the block count.
    logic [127:0] model_mem [256];
    bit           model_valid [256];
    logic [127:0] model_rd;

    typedef struct {
        bit           wr;
        bit           rd;
        logic [27:0]  addr;
        logic [127:0] data;
        int           exp_busy;
        logic [127:0] exp_rd;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_op(input bit wr, input bit rd, input logic [27:0] addr,
                            input logic [127:0] data);
        int idx;
        idx = int'(addr % 28'd256);
        if (wr) begin
            model_mem[idx]   = data;
            model_valid[idx] = 1'b1;
        end else if (rd) begin
            model_rd = model_mem[idx];
        end
    endtask

    // Called just after a posedge with the DUT idle; returns BUSYWAIT-high cycle count.
    task automatic access(input bit wr, input bit rd, input logic [27:0] addr,
                          input logic [127:0] data, output int busy, output logic [127:0] rdata);
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = data;
        busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!BUSYWAIT) break;
            busy++;
            @(posedge CLK); #1;
        end
        rdata = READDATA;
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic op_checked(input string name, input bit wr, input bit rd,
                              input logic [27:0] addr, input logic [127:0] data);
        int           busy;
        logic [127:0] rdata;
        access(wr, rd, addr, data, busy, rdata);
        model_op(wr, rd, addr, data);
        check({name, "_busy"}, 128'(busy), 128'(LAT + 1));
        check({name, "_rdata"}, rdata, model_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           busy, first_low, second_low;
        logic [127:0] rdata, rd1, rd2, rnd;
        logic [27:0]  raddr;
        logic [2:0]   bw;
        int           op;

        tbl[0] = '{1'b1, 1'b0, 28'h0000005, D1,       LAT + 1, 128'h0};
        tbl[1] = '{1'b0, 1'b1, 28'h0000005, 128'h0,   LAT + 1, D1};
        tbl[2] = '{1'b0, 1'b1, 28'h0000105, 128'h0,   LAT + 1, D1};
        tbl[3] = '{1'b1, 1'b1, 28'h0000009, 128'h1234, LAT + 1, D1};
        tbl[4] = '{1'b0, 1'b1, 28'h0000009, 128'h0,   LAT + 1, 128'h1234};
        tbl[5] = '{1'b1, 1'b0, 28'h0000007, D4,       LAT + 1, 128'h1234};
        tbl[6] = '{1'b1, 1'b0, 28'hFFFFFFF, D2,       LAT + 1, 128'h1234};
        tbl[7] = '{1'b0, 1'b1, 28'h00000FF, 128'h0,   LAT + 1, D2};
        tbl[8] = '{1'b1, 1'b0, 28'h1000000, D3,       LAT + 1, D2};
        tbl[9] = '{1'b0, 1'b1, 28'h0000100, 128'h0,   LAT + 1, D3};

        for (int i = 0; i < 256; i++) model_valid[i] = 1'b0;
        model_rd = '0;

        // Reset with READ asserted: BUSYWAIT must still be forced low.
        RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        READ1 = 1'b0; WRITE1 = 1'b0; ADDRESS1 = '0; WRITEDATA1 = '0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("reset_busywait", 128'(BUSYWAIT), 128'h0);
        check("reset_readdata", READDATA, 128'h0);
        check("reset_readdata_lat1", READDATA1, 128'h0);
        @(posedge CLK); #1;
        RESET = 1'b0; READ = 1'b0;
        @(negedge CLK);
        check("idle_busywait", 128'(BUSYWAIT), 128'h0);
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
        check("proto_err_clear", 128'(PROTOCOL_ERR), 128'h0);
`endif
        @(posedge CLK); #1;

        for (int i = 0; i < 10; i++) begin
            access(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, busy, rdata);
            model_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data);
            check($sformatf("tbl%0d_busy", i), 128'(busy), 128'(tbl[i].exp_busy));
            check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
        end
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
        check("proto_err_rw", 128'(PROTOCOL_ERR), 128'h1);
`endif

        // Reset in cycle 3 of a write: aborted, array untouched.
        WRITE = 1'b1; ADDRESS = 28'h7; WRITEDATA = '1;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        RESET = 1'b1; WRITE = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_rd = '0;
        @(negedge CLK);
        check("abort_busywait", 128'(BUSYWAIT), 128'h0);
        check("abort_readdata", READDATA, 128'h0);
        @(posedge CLK); #1;
        op_checked("abort_reread", 1'b0, 1'b1, 28'h7, '0);

        // Inputs changed during BUSY must not affect the latched read.
        READ = 1'b1; ADDRESS = 28'h5;
        busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!BUSYWAIT) break;
            busy++;
            @(posedge CLK); #1;
            if (c == 0) begin
                ADDRESS = 28'h9; WRITE = 1'b1; WRITEDATA = '1;
            end
        end
        rdata = READDATA;
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
        model_op(1'b0, 1'b1, 28'h5, '0);
        check("ignore_busy", 128'(busy), 128'(LAT + 1));
        check("ignore_rdata", rdata, model_rd);
        op_checked("ignore_reread9", 1'b0, 1'b1, 28'h9, '0);

        // Back-to-back reads with the request held into the cycle after DONE.
        op_checked("b2b_w1", 1'b1, 1'b0, 28'h1, D4 ^ D5);
        op_checked("b2b_w2", 1'b1, 1'b0, 28'h2, D5);
        READ = 1'b1; ADDRESS = 28'h1;
        first_low = -1; second_low = -1; rd1 = '0; rd2 = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                if (first_low < 0) begin
                    first_low = c; rd1 = READDATA;
                end else begin
                    second_low = c; rd2 = READDATA;
                    break;
                end
            end
            @(posedge CLK); #1;
            if (first_low >= 0 && c == first_low) ADDRESS = 28'h2;
        end
        @(posedge CLK); #1;
        READ = 1'b0;
        check("b2b_first_low", 128'(first_low), 128'(LAT + 1));
        check("b2b_second_low", 128'(second_low), 128'(2 * (LAT + 2) - 1));
        check("b2b_rd1", rd1, model_mem[1]);
        check("b2b_rd2", rd2, model_mem[2]);
        model_rd = model_mem[2];

        // LATENCY=1 instance: BUSYWAIT high cycles 0..1, result in cycle 2.
        WRITE1 = 1'b1; ADDRESS1 = 28'h3; WRITEDATA1 = D5;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            bw[c] = BUSYWAIT1;
            @(posedge CLK); #1;
        end
        WRITE1 = 1'b0;
        check("lat1_wr_pattern", 128'(bw), 128'b011);
        READ1 = 1'b1;
        rd1 = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            bw[c] = BUSYWAIT1;
            if (c == 1) rd1 = READDATA1;
            if (c == 2) rd2 = READDATA1;
            @(posedge CLK); #1;
        end
        READ1 = 1'b0;
        check("lat1_rd_pattern", 128'(bw), 128'b011);
        check("lat1_rd_early", rd1, 128'h0);
        check("lat1_rd_data", rd2, D5);

        // Random traffic against the array model, upper address bits randomized.
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 2));
            raddr = 28'($urandom);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            if (op == 0 && !model_valid[int'(raddr % 28'd256)]) op = 1;
            op_checked($sformatf("rnd%0d", n), op != 0, op != 1, raddr, rnd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LATENCY, default 5, number of BUSY cycles per access (legal range 1..15).
REQ-002 Parameter DEPTH_LOG2, default 8, log2 of the number of 128-bit blocks stored.
REQ-003 CLK  input  1  single clock; all state changes on posedge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 READ  input  1  block read request from data cache controller, held until BUSYWAIT low.
REQ-006 WRITE  input  1  block write-back request, held until BUSYWAIT low.
REQ-007 ADDRESS  input  28  block address (byte address [31:4]).
REQ-008 WRITEDATA  input  128  block to write; word 0 in [31:0].
REQ-009 READDATA  output  128  registered block read result.
REQ-010 BUSYWAIT  output  1  high while a request is pending and not yet completed.

Function
REQ-011 FSM states SHALL be IDLE, BUSY, DONE; 4-bit down-counter CNT.
REQ-012 IDLE: BUSYWAIT = READ|WRITE (combinational); at posedge with READ|WRITE, latch ADDRESS, op and WRITEDATA, load CNT=LATENCY-1, go BUSY.
REQ-013 BUSY: BUSYWAIT=1; CNT decrements each cycle; when CNT==0 perform access at latched address and go DONE.
REQ-014 Read access SHALL load READDATA from the array; write access SHALL update the array, READDATA unchanged.
REQ-015 DONE: BUSYWAIT=0 for exactly one cycle; next state IDLE regardless of inputs.
REQ-016 Total latency: request seen in cycle 0, BUSYWAIT high cycles 0..LATENCY, low and READDATA valid in cycle LATENCY+1.
REQ-017 Back-to-back: a request present in the cycle after DONE SHALL start a new access normally.
REQ-018 READ and WRITE both high in IDLE: SHALL be treated as WRITE.
REQ-019 Input changes during BUSY/DONE SHALL be ignored; latched values govern the access.
REQ-020 Only ADDRESS[DEPTH_LOG2-1:0] SHALL index the array; upper bits alias (wrap-around).
REQ-021 READDATA SHALL hold its last value until the next completed read.

Reset
REQ-022 RESET SHALL force state IDLE, CNT=0, READDATA=0, BUSYWAIT=0 (overriding the combinational term).
REQ-023 RESET mid-access SHALL abort it; an aborted write SHALL NOT modify the array.
REQ-024 Array contents SHALL NOT be cleared by RESET.

Configuration
REQ-025 Macro DATA_MEMORY_PROTOCOL_CHECK_EN defined: add output PROTOCOL_ERR (1 bit), sticky, set when READ&WRITE in IDLE, or when READ/WRITE drops or ADDRESS differs from latched value during BUSY; cleared only by RESET.
REQ-026 Macro undefined: no PROTOCOL_ERR port, no checking logic; all other behaviour identical.

Structure
REQ-027 Shared package/include SHALL hold BLOCK_WIDTH=128, BLOCK_ADDR_WIDTH=28, and FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), reused by the data cache controller.
REQ-028 One sub-module mem_latency_counter (load, decrement, zero flag) SHALL implement CNT; array and FSM stay in data_memory.

Verification
REQ-029 Write ADDRESS=0x0000005, WRITEDATA=0x44443333222211110000FFFF0000AAAA, LATENCY=5 -> BUSYWAIT high 6 cycles, low cycle 6; then read 0x0000005 -> READDATA equals written block in cycle 6.
REQ-030 Read ADDRESS=0x0000105 with DEPTH_LOG2=8 after REQ-029 write -> returns same block (alias).
REQ-031 RESET asserted in cycle 3 of write to 0x07 with data 0xFF..FF -> BUSYWAIT 0 next cycle, READDATA=0, later read of 0x07 returns prior contents.
REQ-032 READ=WRITE=1 in IDLE to 0x09 with data 0x1234 -> write performed; PROTOCOL_ERR=1 when macro defined.
REQ-033 Back-to-back read 0x01 then read 0x02 (request held into cycle after DONE) -> second BUSYWAIT low exactly 2*(LATENCY+2)-1 cycles after first request, correct data each.
REQ-034 LATENCY=1 read -> BUSYWAIT high cycles 0..1, data valid cycle 2.
